bist_sequencer: RTL
===================

// Module: bist_sequencer
// PURPOSE
//  Sequences built-in self-test across NUM_LINKS router links, one link at a time.
//  Pulses each link's BIST reset and waits for that link's receiver to report ready.
//  Records pass/fail/timeout per link and raises a sticky done with aggregate status.
//  Sits beside the router's BIST senders/receivers; the router fabric gates link use on done/all_pass.
// PARAMETERS
//  NUM_LINKS      4                number of links under test (>=1)
//  RESET_CYCLES   2                cycles link_reset[i] is held high per attempt (>=1)
//  TIMEOUT_CYCLES 1040             max WAIT cycles before a link is declared timed out (>=2)
// PORTS
//  clk           in   1                  system clock
//  reset         in   1                  synchronous, active-high reset
//  start         in   1                  1-cycle request to run the full test sequence
//  link_ready    in   NUM_LINKS          per-link receiver ready (test finished or failed)
//  link_failed   in   NUM_LINKS          per-link receiver failed flag (valid when ready)
//  link_reset    out  NUM_LINKS          per-link BIST reset (ORed with system reset outside)
//  link_sel      out  $clog2(NUM_LINKS)  index of link currently under test (min width 1)
//  busy          out  1                  sequence in progress
//  done          out  1                  sticky; sequence complete
//  pass_mask     out  NUM_LINKS          bit i = link i passed
//  fail_mask     out  NUM_LINKS          bit i = link i failed or timed out
//  timeout_mask  out  NUM_LINKS          bit i = link i timed out
//  all_pass      out  1                  done & (pass_mask == all ones)
// BEHAVIOUR
//  - Reset: state IDLE; link_reset='0, link_sel=0, busy=0, done=0, all masks='0, all_pass=0.
//  - States: IDLE, RST_LINK, WAIT, RECORD, DONE. busy=1 in RST_LINK/WAIT/RECORD.
//  - IDLE/DONE + start: clear masks, done<=0, link_sel<=0, cnt<=0, ->RST_LINK. start ignored when busy.
//  - RST_LINK: link_reset[link_sel]=1 (only that bit, registered) for exactly RESET_CYCLES cycles; cnt<=0; ->WAIT.
//  - WAIT: cnt increments each cycle. link_ready[link_sel]=1 -> latch link_failed[link_sel], ->RECORD.
//    cnt==TIMEOUT_CYCLES-1 with no ready -> set timeout_mask and fail_mask bits, ->RECORD.
//    ready and timeout in same cycle: ready wins, no timeout bit.
//  - RECORD (1 cycle): set pass_mask or fail_mask bit from latched result;
//    link_sel==NUM_LINKS-1 -> DONE, else link_sel+1 -> RST_LINK.
//  - DONE: done=1, all_pass valid; hold until start or reset. link_sel holds last index.
//  - Inputs for links other than link_sel are ignored. pass_mask & fail_mask always '0.
//  - Reset mid-sequence: all state/outputs to reset values on next edge; link_reset drops to '0.
//  - cnt width $clog2(TIMEOUT_CYCLES+1); never wraps (bounded by timeout).
// CONFIGURATION
//  BIST_RETRY_EN defined: a link failing (not timing out) on first attempt is re-run once
//   (RECORD -> RST_LINK, same link_sel). Retry result is final. Adds output port
//   retry_mask [NUM_LINKS] (bit i = link i was retried), reset '0, cleared on start.
//  BIST_RETRY_EN undefined: first result is final; retry_mask port absent.
// STRUCTURE
//  - bist_pkg: state enum bist_seq_state_e, BIST_RESET_CYCLES_DEF/BIST_TIMEOUT_DEF constants.
//  - One sub-module: bist_watchdog (loadable up-counter with clear, terminal-count flag)
//    shared by RST_LINK hold timing and WAIT timeout; all else in one FSM process.
// TESTING (NUM_LINKS=4, RESET_CYCLES=2, TIMEOUT_CYCLES=24)
//  - All pass: start; each link ready=1,failed=0 10 cycles after reset drop -> done, pass_mask=4'hF, all_pass=1.
//  - Mixed: link 2 ready with failed=1 -> fail_mask=4'h4, pass_mask=4'hB, all_pass=0.
//  - Timeout: link 1 never ready -> after 24 WAIT cycles timeout_mask=4'h2, fail_mask=4'h2, sequence continues to link 2.
//  - Tie: link 0 ready asserted on WAIT cycle 24 -> pass recorded, timeout_mask=0.
//  - Control: start while busy ignored; reset during WAIT of link 3 -> next cycle all outputs '0;
//    link_reset one-hot, exactly 2 cycles wide per attempt.
//  - BIST_RETRY_EN: link 0 fails then passes on rerun -> pass_mask[0]=1, retry_mask=4'h1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and defaults for the link BIST sequencer.
// Pure declarations, no logic and no latency.
// No flow control.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LINK,
        ST_WAIT,
        ST_RECORD,
        ST_DONE
    } bist_seq_state_e;

    localparam int BIST_RESET_CYCLES_DEF = 2;
    localparam int BIST_TIMEOUT_DEF      = 1040;

    // Larger of two sizing values; used so one counter covers both phases.
    function automatic int bist_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bist_watchdog.sv
// Loadable up-counter with clear and a terminal-count flag.
// cnt updates one cycle after clear/load/en; tc is combinational from cnt.
// No flow control; counts only while en is high.
module bist_watchdog #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    // Counter register: clear has priority over load, load over increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/bist_sequencer.sv
// Runs link BIST one link at a time: reset pulse, wait for ready/timeout, record.
// Per link: RESET_CYCLES + up to TIMEOUT_CYCLES + 1 cycles; masks update registered.
// No backpressure; start is ignored while busy. Optional retry under BIST_RETRY_EN.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int NUM_LINKS      = 4,
    parameter int RESET_CYCLES   = BIST_RESET_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = BIST_TIMEOUT_DEF,
    localparam int SEL_W         = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_LINKS-1:0] link_ready,
    input  logic [NUM_LINKS-1:0] link_failed,
    output logic [NUM_LINKS-1:0] link_reset,
    output logic [SEL_W-1:0]     link_sel,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_LINKS-1:0] pass_mask,
    output logic [NUM_LINKS-1:0] fail_mask,
    output logic [NUM_LINKS-1:0] timeout_mask,
`ifdef BIST_RETRY_EN
    output logic [NUM_LINKS-1:0] retry_mask,
`endif
    output logic                 all_pass
);

    // One counter serves both the reset hold and the wait timeout.
    localparam int CNT_W = $clog2(bist_max(TIMEOUT_CYCLES, RESET_CYCLES) + 1);
    localparam logic [CNT_W-1:0] RST_TERM = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_TERM  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LINKS - 1);

    bist_seq_state_e      state, next_state;
    logic [SEL_W-1:0]     next_sel;
    logic [NUM_LINKS-1:0] next_link_reset;
    logic                 wd_clear, wd_en, wd_tc;
    logic [CNT_W-1:0]     wd_cnt, wd_term;
    logic                 sel_ready, sel_failed;
    logic                 res_fail, res_timeout;
    logic                 do_retry;

    assign sel_ready  = link_ready[link_sel];
    assign sel_failed = link_failed[link_sel];
    assign wd_term    = (state == ST_RST_LINK) ? RST_TERM : TO_TERM;
    // Every phase change restarts the count from zero.
    assign wd_clear   = (next_state != state);

    bist_watchdog #(.CNT_W(CNT_W)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .load     (1'b0),
        .load_val ('0),
        .en       (wd_en),
        .term     (wd_term),
        .cnt      (wd_cnt),
        .tc       (wd_tc)
    );

    // Next-state, next link index, counter enable and next link_reset pattern.
    always_comb begin
        next_state      = state;
        next_sel        = link_sel;
        wd_en           = 1'b0;
        do_retry        = 1'b0;
        next_link_reset = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state = ST_RST_LINK;
                    next_sel   = '0;
                end
            end
            ST_RST_LINK: begin
                wd_en = 1'b1;
                if (wd_tc) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                if (sel_ready || wd_tc) next_state = ST_RECORD;
            end
            ST_RECORD: begin
`ifdef BIST_RETRY_EN
                // Only a genuine first-attempt failure earns a rerun.
                do_retry = res_fail && !res_timeout && !retry_mask[link_sel];
`endif
                if (do_retry) begin
                    next_state = ST_RST_LINK;
                end else if (link_sel == LAST_SEL) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_RST_LINK;
                    next_sel   = link_sel + 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (next_state == ST_RST_LINK) next_link_reset[next_sel] = 1'b1;
    end

    // State, link index and registered one-hot link reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            link_sel   <= '0;
            link_reset <= '0;
        end else begin
            state      <= next_state;
            link_sel   <= next_sel;
            link_reset <= next_link_reset;
        end
    end

    // Result latch and status masks; ready beats timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_mask    <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            res_fail     <= 1'b0;
            res_timeout  <= 1'b0;
`ifdef BIST_RETRY_EN
            retry_mask   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pass_mask    <= '0;
                        fail_mask    <= '0;
                        timeout_mask <= '0;
`ifdef BIST_RETRY_EN
                        retry_mask   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (sel_ready) begin
                        res_fail    <= sel_failed;
                        res_timeout <= 1'b0;
                    end else if (wd_tc) begin
                        res_fail               <= 1'b1;
                        res_timeout            <= 1'b1;
                        timeout_mask[link_sel] <= 1'b1;
                        fail_mask[link_sel]    <= 1'b1;
                    end
                end
                ST_RECORD: begin
                    if (do_retry) begin
`ifdef BIST_RETRY_EN
                        retry_mask[link_sel] <= 1'b1;
`endif
                    end else if (!res_timeout) begin
                        if (res_fail) fail_mask[link_sel] <= 1'b1;
                        else          pass_mask[link_sel] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == ST_RST_LINK) || (state == ST_WAIT) || (state == ST_RECORD);
    assign done     = (state == ST_DONE);
    assign all_pass = done && (&pass_mask);

endmodule
